// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with next-PC selection, circular return-address
// stack, trap/EPC handling with nesting detection and target-alignment checking.
module pc_sequencer #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h00000000,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = 32'h00000100,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4,
    localparam int             CNT_W     = $clog2(RAS_DEPTH + 1),
    localparam int             PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_write,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
    input  logic              trap,
    input  logic              mret,
    output logic [ADDR_W-1:0] pc_current,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] epc,
    output logic              in_trap,
    output logic              double_fault,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_underflow,
    output logic              misalign
);
    // Low log2(INC) bits must be zero for an aligned target.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;     // next free slot; top of stack is ras_ptr-1
    logic [PTR_W-1:0]  ptr_inc, ptr_dec;
    logic [ADDR_W-1:0] ras_top, redir_tgt, pc_next;
    logic take_mret, do_ret, do_jump, do_branch, ret_pop, ret_uflow;
    logic mis_now, enter_trap, ras_push, ras_pop;

    assign pc_plus = pc_current + ADDR_W'(INC);

    // Next-PC selection, RAS control and alignment check
    always_comb begin
        ptr_inc    = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
        ptr_dec    = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
        ras_top    = ras_mem[ptr_dec];
        // mret with in_trap = 0 falls through to the lower priorities
        take_mret  = pc_write & mret & in_trap;
        do_ret     = pc_write & ~take_mret & ret;
        do_jump    = pc_write & ~take_mret & ~ret & jump;
        do_branch  = pc_write & ~take_mret & ~ret & ~jump & branch_taken;
        ret_pop    = do_ret & (ras_count != '0);
        redir_tgt  = ret_pop ? ras_top : (do_jump ? jump_target : branch_target);
        // Misalignment still pulses when an explicit trap arrives in the same cycle
        mis_now    = (ret_pop | do_jump | do_branch) & ((redir_tgt & ALIGN_MASK) != '0);
        enter_trap = trap | mis_now;
        ret_uflow  = ~enter_trap & do_ret & (ras_count == '0);
        ras_pop    = ~enter_trap & ret_pop;
        ras_push   = ~enter_trap & call & (do_jump | do_ret);

        pc_next = pc_current;
        if (enter_trap)       pc_next = TRAP_VEC;
        else if (take_mret)   pc_next = epc;
        else if (ret_pop)     pc_next = ras_top;
        else if (do_ret)      pc_next = pc_plus;
        else if (do_jump)     pc_next = jump_target;
        else if (do_branch)   pc_next = branch_target;
        else if (pc_write)    pc_next = pc_plus;
    end

    // PC, trap state, RAS bookkeeping and status pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_current    <= RESET_VEC;
            epc           <= '0;
            in_trap       <= 1'b0;
            double_fault  <= 1'b0;
            ras_count     <= '0;
            ras_ptr       <= '0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            pc_current    <= pc_next;
            ras_underflow <= ret_uflow;
            misalign      <= mis_now;
            if (enter_trap) begin
                if (!in_trap) begin
                    epc     <= pc_current;
                    in_trap <= 1'b1;
                end else begin
                    double_fault <= 1'b1;
                end
            end else if (take_mret) begin
                in_trap <= 1'b0;
            end
            // Swap (pop+push) keeps pointer and count; top entry is rewritten
            if (ras_pop && !ras_push) begin
                ras_ptr   <= ptr_dec;
                ras_count <= ras_count - 1'b1;
            end else if (ras_push && !ras_pop) begin
                ras_ptr <= ptr_inc;
                if (ras_count != CNT_W'(RAS_DEPTH))
                    ras_count <= ras_count + 1'b1;
            end
        end
    end

    // RAS storage; a full push overwrites the oldest entry by wrapping the pointer
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (ras_push && ras_pop)
                ras_mem[ptr_dec] <= pc_plus;
            else if (ras_push)
                ras_mem[ras_ptr] <= pc_plus;
        end
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter. It owns next-PC selection (sequential, branch, jump, call/return, trap, trap-return), so the datapath only supplies targets and control pulses.
- Adds:
  - a circular return-address stack (RAS)
  - an exception PC (EPC) register with trap-nesting detection
  - target-alignment checking
- Sits at the front of the fetch path and drives the instruction-memory address.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_VEC, 32'h00000000, PC value after reset.
- TRAP_VEC, 32'h00000100, PC value loaded on trap or misalignment.
- INC, 4, sequential increment. Must be a power of two; ALIGN_B = log2(INC).
- RAS_DEPTH, 4, number of return-address entries. Must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- pc_write  in  1  1 = advance PC this cycle; 0 = stall.
- branch_taken  in  1  take branch_target.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  take jump_target.
- jump_target  in  ADDR_W  jump destination.
- call  in  1  qualifies jump: push pc_plus onto the RAS.
- ret  in  1  return: pop the RAS and take the popped address.
- trap  in  1  exception/interrupt request.
- mret  in  1  return from trap to epc.
- pc_current  out  ADDR_W  current PC.
- pc_plus  out  ADDR_W  pc_current + INC, combinational, wraps modulo 2^ADDR_W.
- epc  out  ADDR_W  saved PC of the trapping instruction.
- in_trap  out  1  handler active.
- double_fault  out  1  sticky flag: trap taken while in_trap.
- ras_count  out  clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_underflow  out  1  one-cycle pulse: ret with ras_count == 0.
- misalign  out  1  one-cycle pulse: misaligned redirect converted to trap.

Behaviour:
- Reset (reset_n = 0 at posedge), all outputs:
  - pc_current = RESET_VEC
  - epc = 0
  - in_trap = 0, double_fault = 0
  - ras_count = 0, RAS pointer = 0
  - pulses = 0
- Reset overrides every other input in the same cycle.
- Priority, evaluated each posedge:
  1. trap: taken even when pc_write = 0.
  2. mret: requires in_trap = 1 and pc_write = 1.
  3. ret
  4. jump
  5. branch_taken
  6. sequential
- Items 3 to 6 require pc_write = 1. With pc_write = 0 and no trap: all state holds and pulses are 0.
- Selected targets:
  - trap: pc <= TRAP_VEC. If in_trap = 0: epc <= pc_current and in_trap <= 1. If in_trap = 1: epc unchanged and double_fault <= 1.
  - mret: pc <= epc, in_trap <= 0. mret with in_trap = 0 is ignored and the cycle falls through to the next priority.
  - ret with ras_count > 0: pc <= top entry and ras_count decrements.
  - ret with ras_count == 0: pc <= pc_plus, ras_underflow = 1 for one cycle, count stays 0.
  - ret with call, count > 0 (coroutine swap): pc <= top entry, top entry <= pc_plus, count unchanged. With count == 0: underflow path, and pc_plus is then pushed.
  - jump: pc <= jump_target. If call = 1, pc_plus is pushed.
  - call without jump or ret is ignored.
  - branch_taken: pc <= branch_target.
  - sequential: pc <= pc_plus.
- RAS:
  - Circular buffer.
  - Push when count == RAS_DEPTH overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pointer arithmetic is modulo RAS_DEPTH.
- Alignment:
  - Applies to jump, branch and popped-ret targets.
  - If target[ALIGN_B-1:0] != 0, the redirect is replaced by trap behaviour: pc <= TRAP_VEC, and epc/in_trap/double_fault update per the trap rule.
  - misalign = 1 for one cycle.
  - The RAS push/pop of that instruction is suppressed.
  - TRAP_VEC, RESET_VEC and epc are not checked.
- Latency: every redirect is visible on pc_current one cycle after the qualifying edge; pc_plus follows combinationally.
- Reset deasserted mid-stall: the PC resumes from RESET_VEC on the first edge with pc_write = 1.

Test Plan:
- Reset, then 3 cycles with pc_write = 1 -> pc_current 0x0, 0x4, 0x8, 0xC. Deassert pc_write for 2 cycles -> holds 0xC.
- Sequential wrap: pc_current = 0xFFFFFFFC, one sequential advance -> pc_current = 0x00000000.
- At pc 0x10, jump+call to 0x200 -> pc 0x200, ras_count = 1. Then ret -> pc 0x14, ras_count = 0. A second ret -> pc 0x18, ras_underflow pulse.
- 5 nested calls with RAS_DEPTH = 4 -> ras_count = 4. Four rets return the 4 newest addresses in LIFO order; the fifth ret underflows.
- trap at pc 0x40 with pc_write = 0 -> pc 0x100, epc = 0x40, in_trap = 1. A second trap -> epc still 0x40, double_fault = 1. mret -> pc 0x40, in_trap = 0.
- jump to 0x202 -> misalign pulse, pc 0x100, epc = old pc, no RAS change. Same cycle with trap asserted as well -> single trap, misalign still pulses.
